// File: rtl/post_adder_alu.sv
// post_adder_alu: WIDTH-bit post-adder/ALU stage of the PIRDSP slice.
//
// Adds or subtracts the X, Y and Z operands plus CIN, or forms a bitwise
// logic function of X and Z. The datapath can be split into one, two or
// four independent SIMD lanes. The result can be registered or taken
// combinationally.
//
// Optional feature: define PATTERN_DETECT_EN to build the masked pattern
// comparator that drives PATTERNDETECT. Without it, PATTERNDETECT is tied
// to 0 and no compare logic is built.
//
// Parameters:
//   WIDTH   - datapath width; must be divisible by 4
//   PATTERN - pattern-detect compare value
//   MASK    - pattern-detect mask (1 = bit ignored)
//
// Ports:
//   clk                  - slice clock
//   reset                - asynchronous active-high reset; forces all outputs to 0
//   RSTP / CEP           - synchronous clear / enable of the P register
//   RSTALUMODE/CEALUMODE - synchronous clear / enable of the ALUMODE register
//   ALUMODE              - operation select
//   X, Y, Z, CIN         - operands and carry-in (CIN goes to lane 0 only)
//   P, P_msb             - result and its top bit
//   CARRYOUT             - per-lane carries; CARRYCASCOUT = CARRYOUT[3]
//   PATTERNDETECT        - masked pattern match
//   configuration_*      - serial configuration chain:
//                          in -> PREG -> ALUMODEREG -> USE_SIMD[0] -> USE_SIMD[1] -> out
module post_adder_alu #(
    parameter int unsigned      WIDTH   = 48,
    parameter logic [WIDTH-1:0] PATTERN = '0,
    parameter logic [WIDTH-1:0] MASK    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RSTP,
    input  logic             RSTALUMODE,
    input  logic             CEP,
    input  logic             CEALUMODE,
    input  logic [3:0]       ALUMODE,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    input  logic             CIN,
    output logic [WIDTH-1:0] P,
    output logic             P_msb,
    output logic [3:0]       CARRYOUT,
    output logic             CARRYCASCOUT,
    output logic             PATTERNDETECT,
    input  logic             configuration_input,
    input  logic             configuration_enable,
    output logic             configuration_output
);

    // Quarter width: the smallest SIMD lane.
    localparam int unsigned QW = WIDTH / 4;

    // ------------------------------------------------------------------
    // Configuration chain
    // ------------------------------------------------------------------
    logic       preg_q;
    logic       alumodereg_q;
    logic [1:0] use_simd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preg_q       <= 1'b0;
            alumodereg_q <= 1'b0;
            use_simd_q   <= 2'b00;
        end else if (configuration_enable) begin
            preg_q       <= configuration_input;
            alumodereg_q <= preg_q;
            use_simd_q   <= {use_simd_q[0], alumodereg_q};
        end
    end

    assign configuration_output = use_simd_q[1];

    // ------------------------------------------------------------------
    // ALUMODE register
    // ------------------------------------------------------------------
    logic [3:0] alumode_q;
    logic [3:0] mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alumode_q <= 4'b0000;
        end else if (RSTALUMODE) begin
            alumode_q <= 4'b0000;
        end else if (CEALUMODE) begin
            alumode_q <= ALUMODE;
        end
    end

    assign mode = alumodereg_q ? alumode_q : ALUMODE;

    // ------------------------------------------------------------------
    // Adder: four quarter-width slices chained through a 2-bit carry.
    // Three operands plus carry can overflow a slice by up to 2, so the
    // chain value is the slice sum's top two bits. lane_end marks slices
    // that close a SIMD lane; the chain is cut there and the lane carry is
    // bit 0 of the cut value (bit [lane width] of the full lane sum).
    // ------------------------------------------------------------------
    logic [3:0]       lane_end;
    logic [WIDTH-1:0] z_op;
    logic [WIDTH-1:0] sum_full;
    logic [3:0]       carry_arith;
    logic [QW+1:0]    qsum;
    logic [1:0]       chain;

    always_comb begin
        if (use_simd_q[1]) begin
            lane_end = 4'b1111;
        end else if (use_simd_q[0]) begin
            lane_end = 4'b1010;
        end else begin
            lane_end = 4'b1000;
        end

        z_op        = mode[0] ? ~Z : Z;
        chain       = {1'b0, CIN};
        sum_full    = '0;
        carry_arith = '0;
        qsum        = '0;
        for (int q = 0; q < 4; q++) begin
            qsum = {2'b00, X[q*QW +: QW]} + {2'b00, Y[q*QW +: QW]}
                 + {2'b00, z_op[q*QW +: QW]} + {{QW{1'b0}}, chain};
            sum_full[q*QW +: QW] = qsum[QW-1:0];
            carry_arith[q]       = qsum[QW] & lane_end[q];
            chain                = lane_end[q] ? 2'b00 : qsum[QW+1:QW];
        end
    end

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_full;
    logic [3:0]       carry_lane;

    always_comb begin
        r_full     = '0;
        carry_lane = '0;
        unique case (mode[3:2])
            2'b00: begin
                // Inverting the whole word inverts every lane independently.
                r_full     = mode[1] ? ~sum_full : sum_full;
                carry_lane = carry_arith;
            end
            2'b01:   r_full = X ^ Z;
            2'b10:   r_full = X & Z;
            2'b11:   r_full = X | Z;
            default: r_full = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // P register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] p_q;
    logic [3:0]       carry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q     <= '0;
            carry_q <= '0;
        end else if (RSTP) begin
            p_q     <= '0;
            carry_q <= '0;
        end else if (CEP) begin
            p_q     <= r_full;
            carry_q <= carry_lane;
        end
    end

    // With PREG=0 the outputs are combinational, so reset must gate them
    // directly to reach 0 without a clock edge.
    assign P            = reset ? '0 : (preg_q ? p_q : r_full);
    assign CARRYOUT     = reset ? '0 : (preg_q ? carry_q : carry_lane);
    assign P_msb        = P[WIDTH-1];
    assign CARRYCASCOUT = CARRYOUT[3];

    // ------------------------------------------------------------------
    // Pattern detect
    // ------------------------------------------------------------------
`ifdef PATTERN_DETECT_EN
    logic pd_d;
    logic pd_q;

    assign pd_d = ((r_full ^ PATTERN) & ~MASK) == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pd_q <= 1'b0;
        end else if (RSTP) begin
            pd_q <= 1'b0;
        end else if (CEP) begin
            pd_q <= pd_d;
        end
    end

    assign PATTERNDETECT = reset ? 1'b0 : (preg_q ? pd_q : pd_d);
`else
    // Compare parameters have no consumer in this build.
    logic unused_pattern;
    assign unused_pattern = ^{PATTERN, MASK};
    assign PATTERNDETECT  = 1'b0;
`endif

endmodule

// File: tb/tb_post_adder_alu.sv
module tb_post_adder_alu;

    localparam int unsigned W = 48;
    localparam logic [W-1:0] PAT = 48'h0;
    localparam logic [W-1:0] MSK = 48'hFFFF_FFFF_FF00;

    logic         clk;
    logic         reset;
    logic         RSTP, RSTALUMODE, CEP, CEALUMODE;
    logic [3:0]   ALUMODE;
    logic [W-1:0] X, Y, Z;
    logic         CIN;
    logic [W-1:0] P;
    logic         P_msb;
    logic [3:0]   CARRYOUT;
    logic         CARRYCASCOUT;
    logic         PATTERNDETECT;
    logic         configuration_input, configuration_enable, configuration_output;

    int checks = 0;
    int errors = 0;

    post_adder_alu #(
        .WIDTH  (W),
        .PATTERN(PAT),
        .MASK   (MSK)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .RSTP                (RSTP),
        .RSTALUMODE          (RSTALUMODE),
        .CEP                 (CEP),
        .CEALUMODE           (CEALUMODE),
        .ALUMODE             (ALUMODE),
        .X                   (X),
        .Y                   (Y),
        .Z                   (Z),
        .CIN                 (CIN),
        .P                   (P),
        .P_msb               (P_msb),
        .CARRYOUT            (CARRYOUT),
        .CARRYCASCOUT        (CARRYCASCOUT),
        .PATTERNDETECT       (PATTERNDETECT),
        .configuration_input (configuration_input),
        .configuration_enable(configuration_enable),
        .configuration_output(configuration_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane-by-lane reference: returns {pd, carry[3:0], p}.
    function automatic logic [W+4:0] model(input logic [1:0] simd, input logic [3:0] mode,
                                           input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] z, input logic cin);
        int n;
        int lw;
        longint unsigned m, xl, yl, zl, s, r;
        logic [63:0] xv, yv, zv, pv;
        logic [3:0] c;
        logic pd;
        n  = simd[1] ? 4 : (simd[0] ? 2 : 1);
        lw = W / n;
        m  = (64'd1 << lw) - 64'd1;
        xv = {16'h0, x};
        yv = {16'h0, y};
        zv = {16'h0, z};
        pv = '0;
        c  = '0;
        for (int l = 0; l < n; l++) begin
            xl = (xv >> (l * lw)) & m;
            yl = (yv >> (l * lw)) & m;
            zl = (zv >> (l * lw)) & m;
            case (mode[3:2])
                2'b00: begin
                    if (mode[0]) zl = ~zl & m;
                    s = zl + xl + yl + ((l == 0) ? longint'(cin) : 0);
                    r = mode[1] ? ~s : s;
                    c[(l + 1) * (4 / n) - 1] = s[lw];
                end
                2'b01:   r = xl ^ zl;
                2'b10:   r = xl & zl;
                default: r = xl | zl;
            endcase
            pv = pv | ((r & m) << (l * lw));
        end
`ifdef PATTERN_DETECT_EN
        pd = ((pv[W-1:0] ^ PAT) & ~MSK) == '0;
`else
        pd = 1'b0;
`endif
        return {pd, c, pv[W-1:0]};
    endfunction

    // Shift cfg = {USE_SIMD[1], USE_SIMD[0], ALUMODEREG, PREG}; MSB goes in first.
    task automatic shift_cfg(input logic [3:0] cfg);
        configuration_enable = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            configuration_input = cfg[i];
            tick();
        end
        configuration_enable = 1'b0;
        configuration_input  = 1'b0;
    endtask

    task automatic set_ops(input logic [3:0] mode, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] z, input logic cin);
        ALUMODE = mode;
        X = x;
        Y = y;
        Z = z;
        CIN = cin;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (P !== '0 || CARRYOUT !== 4'b0 || configuration_output !== 1'b0
            || PATTERNDETECT !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: P=%h CO=%b cfgout=%b pd=%b, want all 0",
                     P, CARRYOUT, configuration_output, PATTERNDETECT);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (P !== '0 || CARRYOUT !== 4'b0) begin
            errors++;
            $display("FAIL after_reset: P=%h CO=%b, want 0", P, CARRYOUT);
        end
    endtask

    task automatic test_config_chain();
        logic [3:0] cfg;
        cfg = 4'b1011;
        shift_cfg(cfg);
        configuration_enable = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            checks++;
            if (configuration_output !== cfg[i]) begin
                errors++;
                $display("FAIL cfg_readback[%0d]: got %b want %b", i, configuration_output, cfg[i]);
            end
            tick();
        end
        configuration_enable = 1'b0;
    endtask

    task automatic test_directed();
        CEP = 1'b0;
        shift_cfg(4'b0001);
        set_ops(4'b0000, 48'd1, 48'd2, 48'd3, 1'b1);
        CEP = 1'b1;
        #1;
        checks++;
        if (P !== '0) begin
            errors++;
            $display("FAIL preg_latency: P=%h before edge, want 0", P);
        end
        tick();
        checks++;
        if (P !== 48'd7 || CARRYOUT !== 4'b0) begin
            errors++;
            $display("FAIL add_basic: P=%h CO=%b want 7/0000", P, CARRYOUT);
        end
        set_ops(4'b0000, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd1, 1'b0);
        tick();
        checks++;
        if (P !== '0 || CARRYOUT !== 4'b1000 || CARRYCASCOUT !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: P=%h CO=%b cc=%b want 0/1000/1", P, CARRYOUT, CARRYCASCOUT);
        end
        set_ops(4'b0011, 48'd3, 48'd2, 48'd10, 1'b1);
        tick();
        checks++;
        if (P !== 48'd4) begin
            errors++;
            $display("FAIL mode_0011: P=%h want 4", P);
        end
        set_ops(4'b0001, 48'd3, 48'd2, 48'd10, 1'b1);
        tick();
        checks++;
        if (P !== 48'hFFFF_FFFF_FFFB || P_msb !== 1'b1) begin
            errors++;
            $display("FAIL mode_0001: P=%h msb=%b want FFFFFFFFFFFB/1", P, P_msb);
        end
    endtask

    task automatic test_four12();
        shift_cfg(4'b1001);
        set_ops(4'b0000, 48'h001_001_001_FFF, 48'd0, 48'h001_001_001_001, 1'b0);
        tick();
        checks++;
        if (P !== 48'h002_002_002_000 || CARRYOUT !== 4'b0001) begin
            errors++;
            $display("FAIL four12_lanes: P=%h CO=%b want 002002002000/0001", P, CARRYOUT);
        end
    endtask

    task automatic test_rstp();
        shift_cfg(4'b0001);
        set_ops(4'b0000, 48'hFFFF_FFFF_FFFF, 48'd5, 48'd5, 1'b1);
        CEP  = 1'b1;
        RSTP = 1'b1;
        tick();
        checks++;
        if (P !== '0 || CARRYOUT !== 4'b0) begin
            errors++;
            $display("FAIL rstp_wins: P=%h CO=%b want 0", P, CARRYOUT);
        end
        RSTP = 1'b0;
        CEP  = 1'b0;
        tick();
        checks++;
        if (P !== '0) begin
            errors++;
            $display("FAIL cep_hold: P=%h want 0", P);
        end
        CEP = 1'b1;
        tick();
        checks++;
        if (P !== 48'd10 || CARRYOUT !== 4'b1000) begin
            errors++;
            $display("FAIL cep_load: P=%h CO=%b want a/1000", P, CARRYOUT);
        end
    endtask

    task automatic test_alumode_reg();
        shift_cfg(4'b0011);
        CEP = 1'b1;
        set_ops(4'b0011, 48'd3, 48'd2, 48'd10, 1'b1);
        CEALUMODE = 1'b1;
        tick();
        CEALUMODE = 1'b0;
        ALUMODE   = 4'b0000;
        tick();
        checks++;
        if (P !== 48'd4) begin
            errors++;
            $display("FAIL alumode_reg_used: P=%h want 4", P);
        end
        RSTALUMODE = 1'b1;
        CEALUMODE  = 1'b1;
        ALUMODE    = 4'b0001;
        tick();
        RSTALUMODE = 1'b0;
        CEALUMODE  = 1'b0;
        tick();
        checks++;
        if (P !== 48'd16) begin
            errors++;
            $display("FAIL rstalumode_wins: P=%h want 10", P);
        end
    endtask

    task automatic test_pattern();
        logic exp1;
        logic exp0;
`ifdef PATTERN_DETECT_EN
        exp1 = 1'b1;
`else
        exp1 = 1'b0;
`endif
        exp0 = 1'b0;
        shift_cfg(4'b0000);
        set_ops(4'b0000, 48'h300, 48'd0, 48'd0, 1'b0);
        #1;
        checks++;
        if (PATTERNDETECT !== exp1) begin
            errors++;
            $display("FAIL pd_match: got %b want %b", PATTERNDETECT, exp1);
        end
        X = 48'h301;
        #1;
        checks++;
        if (PATTERNDETECT !== exp0) begin
            errors++;
            $display("FAIL pd_nomatch: got %b want %b", PATTERNDETECT, exp0);
        end
    endtask

    task automatic test_random();
        logic [W+4:0] exp;
        logic [3:0]   mode;
        logic [W-1:0] x, y, z;
        logic         cin;
        CEP = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int pr = 0; pr < 2; pr++) begin
                logic [1:0] simd;
                simd = 2'(s);
                shift_cfg({simd, 1'b0, 1'(pr)});
                for (int k = 0; k < 12; k++) begin
                    mode = 4'($urandom);
                    x = {16'($urandom), 32'($urandom)};
                    y = {16'($urandom), 32'($urandom)};
                    z = {16'($urandom), 32'($urandom)};
                    if (($urandom % 4) == 0) x = '1;
                    cin = 1'($urandom);
                    exp = model(simd, mode, x, y, z, cin);
                    set_ops(mode, x, y, z, cin);
                    if (pr == 1) tick();
                    else #1;
                    checks++;
                    if (P !== exp[W-1:0]) begin
                        errors++;
                        $display("FAIL rand_p simd=%b preg=%0d mode=%b: P=%h want %h",
                                 simd, pr, mode, P, exp[W-1:0]);
                    end
                    checks++;
                    if (CARRYOUT !== exp[W+3:W]) begin
                        errors++;
                        $display("FAIL rand_carry simd=%b preg=%0d mode=%b: CO=%b want %b",
                                 simd, pr, mode, CARRYOUT, exp[W+3:W]);
                    end
                    checks++;
                    if (P_msb !== exp[W-1] || CARRYCASCOUT !== exp[W+3]
                        || PATTERNDETECT !== exp[W+4]) begin
                        errors++;
                        $display("FAIL rand_flags: msb=%b cc=%b pd=%b want %b/%b/%b",
                                 P_msb, CARRYCASCOUT, PATTERNDETECT,
                                 exp[W-1], exp[W+3], exp[W+4]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        shift_cfg(4'b1001);
        CEP = 1'b1;
        set_ops(4'b0000, 48'h800_800_800_800, 48'h7FF_7FF_7FF_7FF, 48'h001_001_001_001, 1'b0);
        tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (P !== '0 || CARRYOUT !== 4'b0 || configuration_output !== 1'b0
            || P_msb !== 1'b0 || PATTERNDETECT !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: P=%h CO=%b cfgout=%b msb=%b want all 0",
                     P, CARRYOUT, configuration_output, P_msb);
        end
        #1;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        RSTP = 1'b0;
        RSTALUMODE = 1'b0;
        CEP = 1'b0;
        CEALUMODE = 1'b0;
        ALUMODE = 4'b0000;
        X = '0;
        Y = '0;
        Z = '0;
        CIN = 1'b0;
        configuration_input = 1'b0;
        configuration_enable = 1'b0;

        test_reset();
        test_config_chain();
        test_directed();
        test_four12();
        test_rstp();
        test_alumode_reg();
        test_pattern();
        test_random();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/post_adder_alu.md
Name: post_adder_alu

Overview:
- 48-bit post-adder/ALU stage of the PIRDSP slice, directly downstream of the carry-in manager.
- Consumes the multiplexed X, Y and Z operands and the CIN bit from the carry-in manager.
- Produces P, P_msb, CARRYOUT and CARRYCASCOUT. P_msb and CARRYCASCOUT feed back to the carry-in manager's CARRYINSEL mux.
- Static configuration is loaded through the slice's serial configuration chain.

Parameters:
- WIDTH, 48, datapath width; must be divisible by 4.
- PATTERN, 48'h0, pattern-detect compare value (used only with PATTERN_DETECT_EN).
- MASK, 48'h0, pattern-detect mask; 1 = bit ignored.

Ports:
- clk  in  1  slice clock
- reset  in  1  asynchronous active-high reset
- RSTP  in  1  synchronous active-high clear of the P register
- RSTALUMODE  in  1  synchronous active-high clear of the ALUMODE register
- CEP  in  1  P register clock enable
- CEALUMODE  in  1  ALUMODE register clock enable
- ALUMODE  in  4  operation select
- X, Y, Z  in  WIDTH  operands
- CIN  in  1  carry-in from the carry-in manager
- P  out  WIDTH  result
- P_msb  out  1  equals P[WIDTH-1]
- CARRYOUT  out  4  per-lane carry
- CARRYCASCOUT  out  1  equals CARRYOUT[3]
- PATTERNDETECT  out  1  pattern match (PATTERN_DETECT_EN only)
- configuration_input  in  1  serial config in
- configuration_enable  in  1  config shift enable
- configuration_output  out  1  serial config out

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Configuration chain: shifts on posedge clk while configuration_enable=1, in this order:
  - PREG <= configuration_input
  - ALUMODEREG <= PREG
  - USE_SIMD[0] <= ALUMODEREG
  - USE_SIMD[1] <= USE_SIMD[0]
  - configuration_output = USE_SIMD[1]
- SIMD mode (USE_SIMD):
  - 00 = ONE48: single WIDTH lane.
  - 01 = TWO24: lanes [23:0] and [47:24].
  - 1x = FOUR12: lanes of WIDTH/4 bits.
  - No carry propagates across lane boundaries.
  - CIN is added to lane 0 only.
- ALUMODE register:
  - Priority: RSTALUMODE clears it to 0, else CEALUMODE loads it.
  - Effective mode = register when ALUMODEREG=1, else the ALUMODE input directly.
- Per-lane operation, with S = inner sum, computed at lane width + 2 bits:
  - 0000: S = Z+X+Y+CIN; R = S
  - 0001: S = ~Z+X+Y+CIN; R = S (= X+Y+CIN-Z-1)
  - 0010: S = Z+X+Y+CIN; R = ~S
  - 0011: S = ~Z+X+Y+CIN; R = ~S (= Z-(X+Y+CIN))
  - 01xx: R = X^Z; 10xx: R = X&Z; 11xx: R = X|Z. Y and CIN are ignored in these modes.
  - Lane result = low lane-width bits of R.
  - Lane carry = bit [lane width] of S for arithmetic modes, 0 for logic modes.
- CARRYOUT mapping:
  - ONE48: bit 3 = the lane carry; bits [2:0] = 0.
  - TWO24: bits 1 and 3 = lanes 0 and 1; bits 0 and 2 = 0.
  - FOUR12: bits 0–3 = lanes 0–3.
- P register:
  - Priority: RSTP clears P and CARRYOUT, else CEP loads the result and carries.
  - With PREG=1, outputs come from the register (1 cycle latency from operands/CIN).
  - With PREG=0, outputs are combinational (0 latency).
- Asynchronous reset: clears the config regs, the ALUMODE register, the P register and the PATTERNDETECT register. All outputs go to 0 immediately, including mid-operation and mid-configuration-shift.
- Simultaneous events:
  - RSTP with CEP=1: clear wins.
  - configuration_enable during operation: configuration takes effect the cycle after the shift; the bench must not rely on results during a shift.
- Wrap-around: results are modulo 2^lane-width; overflow is reported only through CARRYOUT.

Optional Feature:
- Macro: PATTERN_DETECT_EN.
- Defined:
  - Unregistered match = ((R_full ^ PATTERN) & ~MASK) == 0, where R_full is the full WIDTH-bit result.
  - PATTERNDETECT follows PREG: registered, with the same RSTP and CEP control as P, when PREG=1; combinational when PREG=0.
- Undefined: PATTERNDETECT is tied to 0 and no compare logic is built.

Test Plan:
- Config shift 4'b0001 (PREG=1, others 0), ONE48, ALUMODE=0000, X=1, Y=2, Z=3, CIN=1 -> P=7 one cycle after the operands; CARRYOUT=0.
- ONE48, mode 0000, X=48'hFFFF_FFFF_FFFF, Y=0, Z=1, CIN=0 -> P=0, CARRYOUT[3]=1, CARRYCASCOUT=1.
- Mode 0011, Z=10, X=3, Y=2, CIN=1 -> P=4. Mode 0001, same operands -> P=-5 (48'hFFFF_FFFF_FFFB), P_msb=1.
- FOUR12, mode 0000, X=48'h001_001_001_FFF, Z=48'h001_001_001_001, Y=0, CIN=0 -> P=48'h002_002_002_000, CARRYOUT=4'b0001.
- PREG=1, CEP=1 with RSTP=1 -> P=0. Assert reset mid-stream -> P, CARRYOUT and configuration_output go to 0 without a clock edge.
- PATTERN_DETECT_EN, PATTERN=48'h0, MASK=48'hFFFF_FFFF_FF00 -> PATTERNDETECT=1 when P[7:0]=0, 0 when P[7:0]=8'h01.
